cache_dm: RTL and testbench

Direct-mapped, write-back, write-allocate cache placed between the mp1 CPU's 16-bit memory port and physical memory. The CPU-side ports match mp1's memory interface, so the cache drops in where the memory model sat. The memory side moves whole 128-bit lines. One multi-state FSM sequences hit service, dirty-line writeback and line allocation.

---
 rtl/cache_dm_if.sv | 37 +++
 rtl/cache_dm.sv | 144 ++++++++++++++
 tb/tb_cache_dm.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_dm_if.sv
// cache_dm_if: bus bundle for the direct-mapped cache.
//   CPU side : mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
//              (requests) and mem_rdata, mem_resp (completion).
//   Memory side : pmem_read, pmem_write, pmem_address, pmem_wdata (line
//              transfer requests) and pmem_rdata, pmem_resp (completion).
// Modports:
//   master - the environment (CPU plus physical memory) driving the cache.
//   slave  - the cache itself.
interface cache_dm_if;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_dm.sv
// cache_dm: direct-mapped, write-back, write-allocate cache between a 16-bit
// CPU memory port and a 128-bit line-oriented physical memory.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-high reset
//   bus        - cache_dm_if.slave (CPU request/response + pmem line bus)
//   hit_count  - 16-bit saturating hit counter   (CACHE_PERF_CNT_EN only)
//   miss_count - 16-bit saturating miss counter  (CACHE_PERF_CNT_EN only)
// Optional feature macro: CACHE_PERF_CNT_EN adds the performance counters.
// Address split: word = [3:1], index = [3+log2(NUM_SETS):4], tag = upper bits.
module cache_dm #(
  parameter int NUM_SETS = 8
) (
  input  logic             clk,
  input  logic             rst,
  cache_dm_if.slave        bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tags  [NUM_SETS];
  logic [127:0]        lines [NUM_SETS];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag_in;
  logic [2:0]          word;
  logic                req;
  logic                hit;
  logic                fill;
  logic                unused_bits;

  function automatic logic [15:0] merge_word(input logic [15:0] old_word,
                                             input logic [15:0] new_word,
                                             input logic [1:0]  be);
    merge_word[7:0]  = be[0] ? new_word[7:0]  : old_word[7:0];
    merge_word[15:8] = be[1] ? new_word[15:8] : old_word[15:8];
  endfunction

  assign idx         = bus.mem_address[4 +: IDX_W];
  assign tag_in      = bus.mem_address[15 -: TAG_W];
  assign word        = bus.mem_address[3:1];
  assign unused_bits = bus.mem_address[0];
  assign req         = bus.mem_read | bus.mem_write;
  assign hit         = valid[idx] && (tags[idx] == tag_in);

  // Hits complete combinationally; gating with rst keeps mem_resp low in reset.
  assign bus.mem_resp  = !rst && (state == CHECK) && req && hit;
  assign bus.mem_rdata = bus.mem_resp ? lines[idx][{word, 4'b0000} +: 16] : '0;
  assign fill          = !rst && (state == ALLOCATE) && bus.pmem_resp;

  // Control path: FSM, valid/dirty bits and registered pmem strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= CHECK;
      valid            <= '0;
      dirty            <= '0;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= '0;
      bus.pmem_wdata   <= '0;
    end else begin
      case (state)
        CHECK: begin
          if (req) begin
            if (hit) begin
              if (bus.mem_write) dirty[idx] <= 1'b1;
            end else if (valid[idx] && dirty[idx]) begin
              state            <= WRITEBACK;
              bus.pmem_write   <= 1'b1;
              bus.pmem_address <= {tags[idx], idx, 4'b0000};
              bus.pmem_wdata   <= lines[idx];
            end else begin
              state            <= ALLOCATE;
              bus.pmem_read    <= 1'b1;
              bus.pmem_address <= {bus.mem_address[15:4], 4'b0000};
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            state            <= ALLOCATE;
            bus.pmem_write   <= 1'b0;
            bus.pmem_read    <= 1'b1;
            bus.pmem_address <= {bus.mem_address[15:4], 4'b0000};
          end
        end
        ALLOCATE: begin
          if (bus.pmem_resp) begin
            state         <= CHECK;
            bus.pmem_read <= 1'b0;
            valid[idx]    <= 1'b1;
            dirty[idx]    <= 1'b0;
          end
        end
        default: state <= CHECK;
      endcase
    end
  end

  // Data path: line and tag storage, no reset (valid bits qualify contents).
  always_ff @(posedge clk) begin
    if (fill) begin
      lines[idx] <= bus.pmem_rdata;
      tags[idx]  <= tag_in;
    end else if (bus.mem_resp && bus.mem_write) begin
      lines[idx][{word, 4'b0000} +: 16] <=
        merge_word(lines[idx][{word, 4'b0000} +: 16], bus.mem_wdata, bus.mem_byte_enable);
    end
  end

`ifdef CACHE_PERF_CNT_EN
  // Set once a line has been filled for the pending request, so the hit that
  // follows the fill is not counted as a first-lookup hit.
  logic filled;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      filled     <= 1'b0;
    end else begin
      if (fill) filled <= 1'b1;
      if (bus.mem_resp) begin
        filled <= 1'b0;
        if (!filled && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end
      if ((state == CHECK) && req && !hit && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_dm.sv
// tb_cache_dm: directed self-checking bench for cache_dm with a
// latency-configurable physical memory responder.
module tb_cache_dm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_dm_if if0();

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_dm #(.NUM_SETS(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(if0)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Physical memory model and bus monitor.
  logic [127:0] mem [4096];
  int           lat = 1;
  logic         hold = 1'b0;
  int           late_req = 0;
  int           late_ack = 0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  int           overlap = 0;
  logic [15:0]  last_rd_addr = '0;
  logic [15:0]  last_wr_addr = '0;
  logic [127:0] last_wdata = '0;

  initial begin
    int   wait_cnt;
    logic prev_rd;
    logic prev_wr;
    wait_cnt = 0;
    prev_rd  = 1'b0;
    prev_wr  = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = {8{4'hA, 12'(i)}};
    mem[1] = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    if0.pmem_resp  = 1'b0;
    if0.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (if0.pmem_read && !prev_rd) begin
        rd_cnt++;
        last_rd_addr = if0.pmem_address;
      end
      if (if0.pmem_write && !prev_wr) begin
        wr_cnt++;
        last_wr_addr = if0.pmem_address;
        last_wdata   = if0.pmem_wdata;
      end
      if (if0.pmem_read && if0.pmem_write) overlap++;
      prev_rd = if0.pmem_read;
      prev_wr = if0.pmem_write;
      if (if0.pmem_resp) begin
        if0.pmem_resp = 1'b0;
        wait_cnt = 0;
      end
      if (late_req != late_ack) begin
        late_ack++;
        if0.pmem_rdata = {8{16'hDEAD}};
        if0.pmem_resp  = 1'b1;
      end else if ((if0.pmem_read || if0.pmem_write) && !hold) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          if (if0.pmem_write) mem[if0.pmem_address[15:4]] = if0.pmem_wdata;
          else if0.pmem_rdata = mem[if0.pmem_address[15:4]];
          if0.pmem_resp = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic cpu(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                     input logic [1:0] be, output logic [15:0] rd, output int cyc);
    @(negedge clk);
    if0.mem_write       = wr;
    if0.mem_read        = !wr;
    if0.mem_address     = addr;
    if0.mem_wdata       = wd;
    if0.mem_byte_enable = be;
    cyc = 0;
    #1;
    while (!if0.mem_resp && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    rd = if0.mem_rdata;
    check_val("resp_seen", 128'(if0.mem_resp), 128'd1);
    @(posedge clk);
    #1;
    if0.mem_read  = 1'b0;
    if0.mem_write = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int          cyc;
    int          rd0;
    int          wr0;
    logic [15:0] alias_addr [4];
    logic [15:0] alias_data [4];
    alias_addr = '{16'h0020, 16'h00A0, 16'h0020, 16'h00A0};
    alias_data = '{16'hA002, 16'hA00A, 16'hA002, 16'hA00A};

    if0.mem_read        = 1'b0;
    if0.mem_write       = 1'b0;
    if0.mem_address     = '0;
    if0.mem_wdata       = '0;
    if0.mem_byte_enable = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_mem_resp", 128'(if0.mem_resp), 128'd0);
    check_val("rst_pmem_read", 128'(if0.pmem_read), 128'd0);
    check_val("rst_pmem_write", 128'(if0.pmem_write), 128'd0);
    check_val("rst_pmem_addr", 128'(if0.pmem_address), 128'd0);
    check_val("rst_pmem_wdata", if0.pmem_wdata, 128'd0);
    check_val("rst_mem_rdata", 128'(if0.mem_rdata), 128'd0);
    rst = 1'b0;

    // Clean miss then same-line hit
    lat = 1;
    cpu(1'b0, 16'h0010, 16'h0, 2'b00, rd, cyc);
    check_val("miss_rdata", 128'(rd), 128'h0000);
    check_val("miss_latency", 128'(cyc), 128'd2);
    check_val("miss_rd_cnt", 128'(rd_cnt), 128'd1);
    check_val("miss_rd_addr", 128'(last_rd_addr), 128'h0010);
    cpu(1'b0, 16'h001E, 16'h0, 2'b00, rd, cyc);
    check_val("hit_rdata", 128'(rd), 128'h0007);
    check_val("hit_latency", 128'(cyc), 128'd0);

    // Write hit, low byte only
    cpu(1'b1, 16'h0012, 16'hABCD, 2'b01, rd, cyc);
    check_val("wr_hit_latency", 128'(cyc), 128'd0);
    check_val("wr_hit_no_pmem", 128'(rd_cnt * 16 + wr_cnt), 128'd16);
    cpu(1'b0, 16'h0012, 16'h0, 2'b00, rd, cyc);
    check_val("wr_merge_rdata", 128'(rd), 128'h00CD);

    // Write with no byte enables leaves data unchanged
    cpu(1'b1, 16'h0014, 16'hFFFF, 2'b00, rd, cyc);
    check_val("be0_latency", 128'(cyc), 128'd0);
    cpu(1'b0, 16'h0014, 16'h0, 2'b00, rd, cyc);
    check_val("be0_rdata", 128'(rd), 128'h0002);

    // Dirty eviction: set 1 tag 0 -> set 1 tag 1 (0x0090)
    lat = 2;
    rd0 = rd_cnt;
    cpu(1'b0, 16'h0090, 16'h0, 2'b00, rd, cyc);
    check_val("dirty_latency", 128'(cyc), 128'd5);
    check_val("dirty_wr_cnt", 128'(wr_cnt), 128'd1);
    check_val("dirty_wr_addr", 128'(last_wr_addr), 128'h0010);
    check_val("dirty_wdata", last_wdata, 128'h0007_0006_0005_0004_0003_0002_00CD_0000);
    check_val("dirty_rd_cnt", 128'(rd_cnt - rd0), 128'd1);
    check_val("dirty_rd_addr", 128'(last_rd_addr), 128'h0090);
    check_val("dirty_rdata", 128'(rd), 128'hA009);
    check_val("no_overlap", 128'(overlap), 128'd0);

    // Evicted line comes back from memory with the merged byte
    lat = 1;
    wr0 = wr_cnt;
    cpu(1'b0, 16'h0012, 16'h0, 2'b00, rd, cyc);
    check_val("refetch_rdata", 128'(rd), 128'h00CD);
    check_val("refetch_latency", 128'(cyc), 128'd2);
    check_val("refetch_no_wb", 128'(wr_cnt - wr0), 128'd0);

    // Reset during ALLOCATE with the fill withheld
    hold = 1'b1;
    @(negedge clk);
    if0.mem_read    = 1'b1;
    if0.mem_address = 16'h0030;
    @(negedge clk);
    #1;
    check_val("alloc_strobe", 128'(if0.pmem_read), 128'd1);
    check_val("alloc_addr", 128'(if0.pmem_address), 128'h0030);
    check_val("alloc_no_resp", 128'(if0.mem_resp), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    if0.mem_read = 1'b0;
    check_val("rst_abort_rd", 128'(if0.pmem_read), 128'd0);
    check_val("rst_abort_wr", 128'(if0.pmem_write), 128'd0);
    late_req++;
    @(negedge clk);
    #1;
    check_val("late_resp_rd", 128'(if0.pmem_read), 128'd0);
    check_val("late_resp_mresp", 128'(if0.mem_resp), 128'd0);
    @(negedge clk);
    #1;
    check_val("late_resp_after", 128'(if0.pmem_read), 128'd0);
    hold = 1'b0;
    rd0 = rd_cnt;
    cpu(1'b0, 16'h0030, 16'h0, 2'b00, rd, cyc);
    check_val("post_rst_rdata", 128'(rd), 128'hA003);
    check_val("post_rst_miss", 128'(rd_cnt - rd0), 128'd1);
    rd0 = rd_cnt;
    cpu(1'b0, 16'h0012, 16'h0, 2'b00, rd, cyc);
    check_val("post_rst_invalid", 128'(rd_cnt - rd0), 128'd1);
    check_val("post_rst_old_rdata", 128'(rd), 128'h00CD);

    // Aliasing reads to set 2 evict each other
    reset_dut();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      cpu(1'b0, alias_addr[i], 16'h0, 2'b00, rd, cyc);
      check_val("alias_rdata", 128'(rd), 128'(alias_data[i]));
      check_val("alias_latency", 128'(cyc), 128'd2);
    end
    check_val("alias_misses", 128'(rd_cnt - rd0), 128'd4);
    check_val("alias_no_wb", 128'(wr_cnt - wr0), 128'd0);

`ifdef CACHE_PERF_CNT_EN
    check_val("cnt_miss4", 128'(miss_count), 128'd4);
    check_val("cnt_hit0", 128'(hit_count), 128'd0);
    @(negedge clk);
    if0.mem_read    = 1'b1;
    if0.mem_address = 16'h00A0;
    repeat (70000) @(negedge clk);
    if0.mem_read = 1'b0;
    @(negedge clk);
    #1;
    check_val("cnt_hit_sat", 128'(hit_count), 128'hFFFF);
    check_val("cnt_miss_hold", 128'(miss_count), 128'd4);
`endif

    check_val("final_overlap", 128'(overlap), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
